dot_prod_pipe: RTL and testbench
================================

DOT_PROD_PIPE -- requirements
Module: dot_prod_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_IN, default 16, meaning element width of both input vectors.
REQ-002 The block SHALL have parameter N_IN, default 8, meaning elements per beat; power of two, >= 2.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 40, meaning accumulator/output width; >= 2*DATA_WIDTH_IN+log2(N_IN)+1.
REQ-004 The block SHALL have parameter SIGNED, default 1, meaning 1 = two's-complement operands, 0 = unsigned.
REQ-005 The block SHALL have port i_clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 The block SHALL have port i_rst, input, 1, meaning reset; asynchronous, active-high.
REQ-007 The block SHALL have port i_valid, input, 1, meaning input beat present.
REQ-008 The block SHALL have port i_last, input, 1, meaning the beat closes the current vector; sampled with i_valid.
REQ-009 The block SHALL have port i_a, input, DATA_WIDTH_IN x N_IN (unpacked array), meaning vector A elements.
REQ-010 The block SHALL have port i_b, input, DATA_WIDTH_IN x N_IN (unpacked array), meaning vector B elements.
REQ-011 The block SHALL have port o_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-012 The block SHALL have port i_ready, input, 1, meaning downstream accepts the result.
REQ-013 The block SHALL have port o_data, output, ACC_WIDTH, meaning the dot-product result.
REQ-014 The block SHALL have port o_valid, output, 1, meaning o_data/o_ovf valid.
REQ-015 The block SHALL have port o_ovf, output, 1, meaning the accumulation overflowed ACC_WIDTH; qualified by o_valid.

Function
REQ-016 A beat SHALL be accepted when i_valid && o_ready; o_ready SHALL equal adv = !(o_valid && !i_ready).
REQ-017 All pipeline registers, including per-stage valid/last flags, SHALL advance only when adv=1 and hold otherwise; no beat SHALL be lost or duplicated.
REQ-018 Stage 1 SHALL register the N_IN products i_a[k]*i_b[k], each 2*DATA_WIDTH_IN bits, signed or unsigned per SIGNED.
REQ-019 Stages 2..1+log2(N_IN) SHALL form a registered pairwise adder tree, each level widening by 1 bit (sign-extended if SIGNED); the tree SHALL never overflow.
REQ-020 The final stage SHALL add the tree sum, extended to ACC_WIDTH, to the accumulator, then clear the accumulator after a beat flagged last.
REQ-021 The first beat after a last, or after reset, SHALL start from accumulator value 0.
REQ-022 o_valid SHALL assert for exactly the accumulator update of a last beat; o_data SHALL be the accumulated sum, wrapped modulo 2^ACC_WIDTH.
REQ-023 Latency from acceptance of a last beat to o_valid, with no stalls, SHALL be log2(N_IN)+2 cycles (5 at defaults).
REQ-024 Throughput SHALL be one beat per cycle while i_ready=1.
REQ-025 o_ovf SHALL be the OR of per-step overflow over all beats of the vector; signed overflow = operands same sign, result sign differs; unsigned = carry out of MSB.
REQ-026 o_ovf SHALL clear together with the accumulator.
REQ-027 While o_valid=1 and i_ready=0, o_data, o_ovf and o_valid SHALL hold unchanged.
REQ-028 Non-last beats SHALL produce no o_valid pulse.

Reset
REQ-029 On i_rst=1, all pipeline valid flags, the accumulator, o_data, o_valid and o_ovf SHALL go to 0 immediately, without waiting for a clock.
REQ-030 Beats in flight at reset SHALL be discarded; partial accumulation SHALL NOT survive reset.
REQ-031 o_ready SHALL be 1 while reset is asserted and after it is released.

Verification
REQ-032 Single beat at defaults: a=all 1, b=1..8, last=1 -> o_valid 5 cycles later, o_data=36, o_ovf=0.
REQ-033 Two-beat vector: beat1 a=all 2, b=all 3; beat2 a=all -1, b=all 5, last -> single o_valid, o_data=8.
REQ-034 Backpressure: hold i_ready=0 for 3 cycles while o_valid=1 -> o_data held, o_ready=0, all following results delivered in order.
REQ-035 Overflow with ACC_WIDTH=36: 4 beats of a=b=all -32768, last on 4th -> o_ovf=1, o_data=-2^35 (wrapped).
REQ-036 Reset mid-vector: non-last beat a=b=all 1, then pulse i_rst, then last beat a=all 1, b=all 2 -> o_data=16.
REQ-037 Back-to-back single-beat vectors, 10 beats, i_ready=1 -> 10 consecutive o_valid cycles with correct values.

Source files
------------

// File: rtl/dot_prod_pipe.sv
// Pipelined N_IN-wide multiply/adder-tree dot product accumulated across beats until i_last.
// Latency log2(N_IN)+2 cycles. A held result (o_valid && !i_ready) freezes every stage and drops o_ready.
module dot_prod_pipe #(
    parameter int DATA_WIDTH_IN = 16,
    parameter int N_IN          = 8,
    parameter int ACC_WIDTH     = 40,
    parameter int SIGNED        = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_last,
    input  logic [DATA_WIDTH_IN-1:0] i_a [N_IN],
    input  logic [DATA_WIDTH_IN-1:0] i_b [N_IN],
    output logic                     o_ready,
    input  logic                     i_ready,
    output logic [ACC_WIDTH-1:0]     o_data,
    output logic                     o_valid,
    output logic                     o_ovf
);
    localparam int LVLS = $clog2(N_IN);
    localparam int DW   = DATA_WIDTH_IN;
    localparam int PW   = 2 * DW;
    localparam int TW   = PW + LVLS;
    localparam bit SGN  = (SIGNED != 0);

    function automatic logic [PW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {{DW{SGN & a[DW-1]}}, a} * {{DW{SGN & b[DW-1]}}, b};
    endfunction

    logic          adv;
    logic [LVLS:0] stg_vld;
    logic [LVLS:0] stg_lst;

    assign adv     = !(o_valid && !i_ready);
    assign o_ready = adv;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stg_vld <= '0;
            stg_lst <= '0;
        end else if (adv) begin
            stg_vld <= {stg_vld[LVLS-1:0], i_valid};
            stg_lst <= {stg_lst[LVLS-1:0], i_valid & i_last};
        end
    end

    // Level 0 holds the products; each later level halves the count and grows one bit.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        localparam int LW = PW + l;
        logic [LW-1:0] sum [N_IN >> l];

        if (l == 0) begin : g_mul
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int k = 0; k < N_IN; k++) sum[k] <= '0;
                end else if (adv) begin
                    for (int k = 0; k < N_IN; k++) sum[k] <= mul(i_a[k], i_b[k]);
                end
            end
        end else begin : g_add
            localparam int IW = LW - 1;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int k = 0; k < (N_IN >> l); k++) sum[k] <= '0;
                end else if (adv) begin
                    for (int k = 0; k < (N_IN >> l); k++)
                        sum[k] <= {SGN & g_lvl[l-1].sum[2*k][IW-1],   g_lvl[l-1].sum[2*k]}
                                + {SGN & g_lvl[l-1].sum[2*k+1][IW-1], g_lvl[l-1].sum[2*k+1]};
                end
            end
        end
    end

    logic [TW-1:0]        tree;
    logic [ACC_WIDTH-1:0] tree_ext;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH:0]   sum_full;
    logic                 ovf_q;
    logic                 ovf_step;

    assign tree     = g_lvl[LVLS].sum[0];
    assign tree_ext = {{(ACC_WIDTH-TW){SGN & tree[TW-1]}}, tree};
    assign sum_full = {1'b0, acc_q} + {1'b0, tree_ext};
    assign acc_sum  = sum_full[ACC_WIDTH-1:0];
    assign ovf_step = SGN ? ((acc_q[ACC_WIDTH-1] == tree_ext[ACC_WIDTH-1]) &&
                             (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                          : sum_full[ACC_WIDTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            o_data  <= '0;
            o_ovf   <= 1'b0;
            o_valid <= 1'b0;
        end else if (adv) begin
            o_valid <= stg_vld[LVLS] & stg_lst[LVLS];
            if (stg_vld[LVLS]) begin
                if (stg_lst[LVLS]) begin
                    o_data <= acc_sum;
                    o_ovf  <= ovf_q | ovf_step;
                    acc_q  <= '0;
                    ovf_q  <= 1'b0;
                end else begin
                    acc_q  <= acc_sum;
                    ovf_q  <= ovf_q | ovf_step;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_prod_pipe.sv
// Directed bench: default-width instance plus a 36-bit accumulator instance sharing stimulus.
module tb_dot_prod_pipe;
    typedef logic [39:0] acc40_t;
    typedef logic [35:0] acc36_t;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_last, i_ready;
    logic [15:0] a_v [8];
    logic [15:0] b_v [8];
    logic        o_ready0, o_valid0, o_ovf0;
    logic        o_ready1, o_valid1, o_ovf1;
    acc40_t      o_data0;
    acc36_t      o_data1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    acc40_t q_data [$];
    logic   q_ovf  [$];
    int     q_cyc  [$];
    acc36_t q1_data[$];
    logic   q1_ovf [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dot_prod_pipe dut0 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_last(i_last),
        .i_a(a_v), .i_b(b_v), .o_ready(o_ready0), .i_ready(i_ready),
        .o_data(o_data0), .o_valid(o_valid0), .o_ovf(o_ovf0)
    );

    dot_prod_pipe #(.ACC_WIDTH(36)) dut1 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_last(i_last),
        .i_a(a_v), .i_b(b_v), .o_ready(o_ready1), .i_ready(i_ready),
        .o_data(o_data1), .o_valid(o_valid1), .o_ovf(o_ovf1)
    );

    // Results are recorded when the downstream handshake completes.
    always @(negedge clk) begin
        if (o_valid0 && i_ready) begin
            q_data.push_back(o_data0);
            q_ovf.push_back(o_ovf0);
            q_cyc.push_back(cyc);
        end
        if (o_valid1 && i_ready) begin
            q1_data.push_back(o_data1);
            q1_ovf.push_back(o_ovf1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ab(input int av, input int bv);
        for (int k = 0; k < 8; k++) begin
            a_v[k] = 16'(av);
            b_v[k] = 16'(bv);
        end
    endtask

    task automatic send(input int av, input int bv, input bit last);
        logic ok;
        ok = 1'b0;
        set_ab(av, bv);
        i_last  = last;
        i_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ok = o_ready0;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("send_timeout", 64'(ok), 64'(1));
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_ovf.delete(); q_cyc.delete();
        q1_data.delete(); q1_ovf.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int t;
        i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
        set_ab(0, 0);
        #1;
        chk("rst_valid", 64'(o_valid0), 64'(0));
        chk("rst_ready", 64'(o_ready0), 64'(1));
        chk("rst_data",  64'(o_data0),  64'(0));
        chk("rst_ovf",   64'(o_ovf0),   64'(0));
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;

        // Single beat: a=1, b=1..8 -> 36 after 5 cycles
        for (int k = 0; k < 8; k++) begin
            a_v[k] = 16'd1;
            b_v[k] = 16'(k + 1);
        end
        i_last = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
        lat = 1;
        while (!o_valid0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency",     64'(lat),      64'(5));
        chk("single_data", 64'(o_data0),  64'(36));
        chk("single_ovf",  64'(o_ovf0),   64'(0));
        @(posedge clk); #1;
        chk("single_pulse", 64'(o_valid0), 64'(0));
        drain();
        clear_q();

        // Two-beat vector: 48 + (-40) = 8
        send(2, 3, 0);
        send(-1, 5, 1);
        drain();
        chk("two_beat_cnt", 64'(q_data.size()), 64'(1));
        if (q_data.size() > 0) begin
            chk("two_beat_data", 64'(q_data[0]), 64'(acc40_t'(8)));
            chk("two_beat_ovf",  64'(q_ovf[0]),  64'(0));
        end
        clear_q();

        // Backpressure: hold the first result for 3 cycles
        fork
            begin
                send(1, 3, 1);
                send(2, -4, 1);
                send(7, 7, 1);
            end
            begin
                t = 0;
                while (!o_valid0 && t < 50) begin
                    @(posedge clk); #1;
                    t++;
                end
                chk("bp_seen", 64'(o_valid0), 64'(1));
                i_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    chk("bp_hold_data",  64'(o_data0),  64'(acc40_t'(24)));
                    chk("bp_hold_valid", 64'(o_valid0), 64'(1));
                    chk("bp_hold_ready", 64'(o_ready0), 64'(0));
                end
                i_ready = 1'b1;
            end
        join
        drain();
        chk("bp_cnt", 64'(q_data.size()), 64'(3));
        if (q_data.size() == 3) begin
            chk("bp_res0", 64'(q_data[0]), 64'(acc40_t'(24)));
            chk("bp_res1", 64'(q_data[1]), 64'(acc40_t'(-64)));
            chk("bp_res2", 64'(q_data[2]), 64'(acc40_t'(392)));
        end
        clear_q();

        // Overflow: 4 x 2^33 = 2^35 wraps in 36 bits, fits in 40
        for (int k = 0; k < 3; k++) send(-32768, -32768, 0);
        send(-32768, -32768, 1);
        drain();
        chk("ovf36_cnt", 64'(q1_data.size()), 64'(1));
        if (q1_data.size() > 0) begin
            chk("ovf36_data", 64'(q1_data[0]), 64'(acc36_t'(36'h8_0000_0000)));
            chk("ovf36_flag", 64'(q1_ovf[0]),  64'(1));
        end
        if (q_data.size() > 0) begin
            chk("ovf40_data", 64'(q_data[0]), 64'(acc40_t'(40'h08_0000_0000)));
            chk("ovf40_flag", 64'(q_ovf[0]),  64'(0));
        end
        clear_q();

        // Reset mid-vector discards the partial sum
        send(1, 1, 0);
        @(posedge clk); #1;
        i_rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(o_valid0), 64'(0));
        chk("midrst_ready", 64'(o_ready0), 64'(1));
        #1;
        i_rst = 1'b0;
        send(1, 2, 1);
        drain();
        chk("midrst_cnt", 64'(q_data.size()), 64'(1));
        if (q_data.size() > 0) chk("midrst_data", 64'(q_data[0]), 64'(acc40_t'(16)));
        clear_q();

        // Ten back-to-back single-beat vectors
        for (int k = 0; k < 10; k++) send(k - 3, k + 2, 1);
        drain();
        chk("b2b_cnt", 64'(q_data.size()), 64'(10));
        for (int k = 0; k < 10 && k < q_data.size(); k++) begin
            chk("b2b_data", 64'(q_data[k]), 64'(acc40_t'(8 * (k - 3) * (k + 2))));
            if (k > 0) chk("b2b_gap", 64'(q_cyc[k] - q_cyc[k-1]), 64'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
